// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: ALU codes, opcodes, FSM states
// and datapath select values.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluAnd  = 4'b0010,
    AluOr   = 4'b0011,
    AluXor  = 4'b0100,
    AluSll  = 4'b0101,
    AluSrl  = 4'b0110,
    AluSlt  = 4'b0111,
    AluSra  = 4'b1110,
    AluSltu = 4'b1111
  } alu_op_e;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExec,
    StAluWb,
    StMem,
    StLoadWb,
    StBrEval,
    StJalrWb,
    StTrap
  } state_e;

  typedef enum logic [1:0] {
    ASelPc    = 2'd0,
    ASelOldPc = 2'd1,
    ASelRs1   = 2'd2
  } a_sel_e;

  typedef enum logic [1:0] {
    BSelRs2    = 2'd0,
    BSelImm    = 2'd1,
    BSelConst4 = 2'd2
  } b_sel_e;

  typedef enum logic [2:0] {
    ImmI = 3'd0,
    ImmS = 3'd1,
    ImmB = 3'd2,
    ImmU = 3'd3,
    ImmJ = 3'd4
  } imm_type_e;

  typedef enum logic [1:0] {
    PcSrcAlu      = 2'd0,
    PcSrcTarget   = 2'd1,
    PcSrcAluAlign = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    ResAlu = 2'd0,
    ResMem = 2'd1,
    ResPc  = 2'd2,
    ResImm = 2'd3
  } result_sel_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OpcStore:          t = ImmS;
      OpcBranch:         t = ImmB;
      OpcLui, OpcAuipc:  t = ImmU;
      OpcJal:            t = ImmJ;
      default:           t = ImmI;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/alu_op_dec.sv
// Combinational ALU operation decode from opcode, funct3 and funct7[5].
module alu_op_dec
  import alu_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output alu_op_e    alu_op_o
);

  always_comb begin
    alu_op_o = AluAdd;
    if (opcode_i == OpcOp || opcode_i == OpcOpImm) begin
      case (funct3_i)
        3'b000:  alu_op_o = (opcode_i == OpcOp && funct7_5_i) ? AluSub : AluAdd;
        3'b001:  alu_op_o = AluSll;
        3'b010:  alu_op_o = AluSlt;
        3'b011:  alu_op_o = AluSltu;
        3'b100:  alu_op_o = AluXor;
        3'b101:  alu_op_o = funct7_5_i ? AluSra : AluSrl;
        3'b110:  alu_op_o = AluOr;
        default: alu_op_o = AluAnd;
      endcase
    end else if (opcode_i == OpcBranch) begin
      case (funct3_i)
        3'b000, 3'b001: alu_op_o = AluSub;
        3'b100, 3'b101: alu_op_o = AluSlt;
        3'b110, 3'b111: alu_op_o = AluSltu;
        default:        alu_op_o = AluAdd;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle RV32I control FSM. Outputs are a Moore decode of the state plus instruction
// fields; ALU results are registered, so decisions on them are taken one state later.
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
#(
  parameter bit          ILLEGAL_HALT = 1'b1,
  parameter int unsigned ALU_CTR_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 zero,
  output logic [ALU_CTR_W-1:0] ALU_ctr,
  output logic [1:0]           alu_a_sel,
  output logic [1:0]           alu_b_sel,
  output logic [2:0]           imm_type,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 oldpc_write,
  output logic                 ir_write,
  output logic                 target_write,
  output logic                 mem_addr_sel,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           result_sel,
  output logic                 illegal
);

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  alu_op_e     dec_op;
  logic        br_taken;
  logic        legal_op;

  alu_op_e     alu_op;
  a_sel_e      a_sel;
  b_sel_e      b_sel;
  imm_type_e   imm_sel;
  pc_src_e     pc_src_sel;
  result_sel_e res_sel;

  logic        unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7_5     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  alu_op_dec u_alu_op_dec (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .alu_op_o   (dec_op)
  );

  always_comb begin
    case (opcode)
      OpcLoad, OpcStore, OpcBranch, OpcJalr, OpcJal,
      OpcOpImm, OpcOp, OpcLui, OpcAuipc: legal_op = 1'b1;
      default:                           legal_op = 1'b0;
    endcase
  end

  // zero holds the registered compare result issued in StExec.
  always_comb begin
    case (funct3)
      3'b000, 3'b101, 3'b111: br_taken = zero;
      3'b001, 3'b100, 3'b110: br_taken = ~zero;
      default:                br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        case (opcode)
          OpcOp, OpcOpImm:         state_d = StAluWb;
          OpcLoad, OpcStore:       state_d = StMem;
          OpcBranch:               state_d = StBrEval;
          OpcJalr:                 state_d = StJalrWb;
          OpcJal, OpcLui, OpcAuipc: state_d = StFetch;
          default:                 state_d = ILLEGAL_HALT ? StTrap : StFetch;
        endcase
        // The flag records any illegal opcode, even when execution continues as a NOP.
        if (!legal_op) begin
          illegal_d = 1'b1;
        end
      end
      StMem:    state_d = (opcode == OpcStore) ? StFetch : StLoadWb;
      StAluWb, StLoadWb, StBrEval, StJalrWb: state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    alu_op       = AluAdd;
    a_sel        = ASelPc;
    b_sel        = BSelRs2;
    imm_sel      = ImmI;
    pc_write     = 1'b0;
    pc_src_sel   = PcSrcAlu;
    oldpc_write  = 1'b0;
    ir_write     = 1'b0;
    target_write = 1'b0;
    mem_addr_sel = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    res_sel      = ResAlu;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          b_sel       = BSelConst4;
          ir_write    = 1'b1;
          oldpc_write = 1'b1;
        end
        StDecode: begin
          pc_write = 1'b1;
          a_sel    = ASelOldPc;
          b_sel    = BSelImm;
          imm_sel  = imm_type_of(opcode);
        end
        StExec: begin
          imm_sel = imm_type_of(opcode);
          case (opcode)
            OpcOp: begin
              alu_op = dec_op;
              a_sel  = ASelRs1;
            end
            OpcOpImm: begin
              alu_op = dec_op;
              a_sel  = ASelRs1;
              b_sel  = BSelImm;
            end
            OpcLoad, OpcStore, OpcJalr: begin
              a_sel = ASelRs1;
              b_sel = BSelImm;
            end
            OpcBranch: begin
              target_write = 1'b1;
              alu_op       = dec_op;
              a_sel        = ASelRs1;
            end
            OpcJal: begin
              pc_write  = 1'b1;
              reg_write = 1'b1;
              res_sel   = ResPc;
            end
            OpcLui: begin
              reg_write = 1'b1;
              res_sel   = ResImm;
            end
            OpcAuipc: reg_write = 1'b1;
            default: ;
          endcase
        end
        StAluWb: reg_write = 1'b1;
        StMem: begin
          mem_addr_sel = 1'b1;
          mem_write    = (opcode == OpcStore);
        end
        StLoadWb: begin
          reg_write = 1'b1;
          res_sel   = ResMem;
        end
        StBrEval: begin
          pc_write   = br_taken;
          pc_src_sel = PcSrcTarget;
        end
        StJalrWb: begin
          pc_write   = 1'b1;
          pc_src_sel = PcSrcAluAlign;
          reg_write  = 1'b1;
          res_sel    = ResPc;
        end
        default: ;
      endcase
    end
  end

  assign ALU_ctr    = ALU_CTR_W'(alu_op);
  assign alu_a_sel  = a_sel;
  assign alu_b_sel  = b_sel;
  assign imm_type   = imm_sel;
  assign pc_src     = pc_src_sel;
  assign result_sel = res_sel;
  assign illegal    = illegal_q & ~reset;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Scoreboard bench for alu_ctrl_fsm: stimulus pushes hand-written expected output vectors,
// a monitor pops one per cycle and compares all control outputs.
module tb_alu_ctrl_fsm;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] imm;
    logic       pcw;
    logic [1:0] pcs;
    logic       oldw;
    logic       irw;
    logic       tw;
    logic       mas;
    logic       mw;
    logic       rw;
    logic [1:0] rs;
    logic       ill;
  } out_t;

  localparam logic [31:0] I_SUB  = 32'h40208033;
  localparam logic [31:0] I_SRAI = 32'h4020D093;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BLTU = 32'h0020E463;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_LW   = 32'h0040A183;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_JALR = 32'h000080E7;
  localparam logic [31:0] I_ILL  = 32'h00000000;

  localparam int unsigned TimeoutCycles = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic [3:0]  ALU_ctr;
  logic [1:0]  alu_a_sel, alu_b_sel, pc_src, result_sel;
  logic [2:0]  imm_type;
  logic        pc_write, oldpc_write, ir_write, target_write;
  logic        mem_addr_sel, mem_write, reg_write, illegal;

  out_t  act;
  out_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  done = 1'b0;

  always #5 clk = ~clk;

  alu_ctrl_fsm #(
    .ILLEGAL_HALT (1'b1),
    .ALU_CTR_W    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .zero         (zero),
    .ALU_ctr      (ALU_ctr),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .imm_type     (imm_type),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .oldpc_write  (oldpc_write),
    .ir_write     (ir_write),
    .target_write (target_write),
    .mem_addr_sel (mem_addr_sel),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .result_sel   (result_sel),
    .illegal      (illegal)
  );

  assign act = {ALU_ctr, alu_a_sel, alu_b_sel, imm_type, pc_write, pc_src, oldpc_write,
                ir_write, target_write, mem_addr_sel, mem_write, reg_write, result_sel, illegal};

  // Monitor: one expected vector per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    out_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %06h expected %06h", n, act, e);
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded number of cycles.
  initial begin
    repeat (TimeoutCycles) @(posedge clk);
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not finish within %0d cycles", TimeoutCycles);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  function automatic out_t idle_e();
    out_t e;
    e = '0;
    return e;
  endfunction

  function automatic out_t fetch_e();
    out_t e;
    e = '0;
    e.b = 2'd2;
    e.oldw = 1'b1;
    e.irw = 1'b1;
    return e;
  endfunction

  function automatic out_t dec_e(input logic [2:0] imm);
    out_t e;
    e = '0;
    e.a = 2'd1;
    e.b = 2'd1;
    e.imm = imm;
    e.pcw = 1'b1;
    return e;
  endfunction

  function automatic out_t ex_e(input logic [3:0] alu, input logic [1:0] a,
                                input logic [1:0] b, input logic [2:0] imm);
    out_t e;
    e = '0;
    e.alu = alu;
    e.a = a;
    e.b = b;
    e.imm = imm;
    return e;
  endfunction

  task automatic cyc(input logic r, input logic [31:0] ins, input logic z, input out_t e,
                     input string n);
    reset = r;
    instr = ins;
    zero  = z;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic alu_seq(input string n, input logic [31:0] ins, input logic [3:0] alu,
                         input logic [1:0] b);
    out_t e;
    cyc(1'b0, ins, 1'b0, fetch_e(), {n, "_fetch"});
    cyc(1'b0, ins, 1'b0, dec_e(3'd0), {n, "_dec"});
    cyc(1'b0, ins, 1'b0, ex_e(alu, 2'd2, b, 3'd0), {n, "_exec"});
    e = idle_e();
    e.rw = 1'b1;
    cyc(1'b0, ins, 1'b0, e, {n, "_wb"});
  endtask

  task automatic br_seq(input string n, input logic [31:0] ins, input logic [3:0] alu,
                        input logic z, input logic taken);
    out_t e;
    cyc(1'b0, ins, 1'b0, fetch_e(), {n, "_fetch"});
    cyc(1'b0, ins, 1'b0, dec_e(3'd2), {n, "_dec"});
    e = ex_e(alu, 2'd2, 2'd0, 3'd2);
    e.tw = 1'b1;
    cyc(1'b0, ins, 1'b0, e, {n, "_exec"});
    e = idle_e();
    e.pcw = taken;
    e.pcs = 2'd1;
    cyc(1'b0, ins, z, e, {n, "_eval"});
  endtask

  initial begin
    out_t e;
    reset = 1'b1;
    instr = I_SUB;
    zero  = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (act !== idle_e()) begin
      errors++;
      $display("FAIL reset_state: got %06h expected %06h", act, idle_e());
    end
    cyc(1'b1, I_SUB, 1'b0, idle_e(), "reset0");
    cyc(1'b1, I_SUB, 1'b0, idle_e(), "reset1");

    alu_seq("sub", I_SUB, 4'b0001, 2'd0);
    alu_seq("srai", I_SRAI, 4'b1110, 2'd1);

    br_seq("beq_taken", I_BEQ, 4'b0001, 1'b1, 1'b1);
    br_seq("beq_not", I_BEQ, 4'b0001, 1'b0, 1'b0);
    br_seq("bltu_taken", I_BLTU, 4'b1111, 1'b0, 1'b1);
    br_seq("bltu_not", I_BLTU, 4'b1111, 1'b1, 1'b0);

    cyc(1'b0, I_SW, 1'b0, fetch_e(), "sw_fetch");
    cyc(1'b0, I_SW, 1'b0, dec_e(3'd1), "sw_dec");
    cyc(1'b0, I_SW, 1'b0, ex_e(4'b0000, 2'd2, 2'd1, 3'd1), "sw_exec");
    e = idle_e();
    e.mas = 1'b1;
    e.mw  = 1'b1;
    cyc(1'b0, I_SW, 1'b0, e, "sw_mem");

    cyc(1'b0, I_LW, 1'b0, fetch_e(), "lw_fetch");
    cyc(1'b0, I_LW, 1'b0, dec_e(3'd0), "lw_dec");
    cyc(1'b0, I_LW, 1'b0, ex_e(4'b0000, 2'd2, 2'd1, 3'd0), "lw_exec");
    e = idle_e();
    e.mas = 1'b1;
    cyc(1'b0, I_LW, 1'b0, e, "lw_mem");
    e = idle_e();
    e.rw = 1'b1;
    e.rs = 2'd1;
    cyc(1'b0, I_LW, 1'b0, e, "lw_wb");

    cyc(1'b0, I_LUI, 1'b0, fetch_e(), "lui_fetch");
    cyc(1'b0, I_LUI, 1'b0, dec_e(3'd3), "lui_dec");
    e = ex_e(4'b0000, 2'd0, 2'd0, 3'd3);
    e.rw = 1'b1;
    e.rs = 2'd3;
    cyc(1'b0, I_LUI, 1'b0, e, "lui_exec");

    cyc(1'b0, I_JAL, 1'b0, fetch_e(), "jal_fetch");
    cyc(1'b0, I_JAL, 1'b0, dec_e(3'd4), "jal_dec");
    e = ex_e(4'b0000, 2'd0, 2'd0, 3'd4);
    e.pcw = 1'b1;
    e.rw  = 1'b1;
    e.rs  = 2'd2;
    cyc(1'b0, I_JAL, 1'b0, e, "jal_exec");

    cyc(1'b0, I_JALR, 1'b0, fetch_e(), "jalr_fetch");
    cyc(1'b0, I_JALR, 1'b0, dec_e(3'd0), "jalr_dec");
    cyc(1'b0, I_JALR, 1'b0, ex_e(4'b0000, 2'd2, 2'd1, 3'd0), "jalr_exec");
    e = idle_e();
    e.pcw = 1'b1;
    e.pcs = 2'd2;
    e.rw  = 1'b1;
    e.rs  = 2'd2;
    cyc(1'b0, I_JALR, 1'b0, e, "jalr_wb");

    cyc(1'b0, I_ILL, 1'b0, fetch_e(), "ill_fetch");
    cyc(1'b0, I_ILL, 1'b0, dec_e(3'd0), "ill_dec");
    cyc(1'b0, I_ILL, 1'b0, idle_e(), "ill_exec");
    e = idle_e();
    e.ill = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, I_ILL, 1'b0, e, "trap_hold");
    end
    cyc(1'b1, I_ILL, 1'b0, idle_e(), "trap_reset");

    cyc(1'b0, I_SW, 1'b0, fetch_e(), "sw2_fetch");
    cyc(1'b0, I_SW, 1'b0, dec_e(3'd1), "sw2_dec");
    cyc(1'b0, I_SW, 1'b0, ex_e(4'b0000, 2'd2, 2'd1, 3'd1), "sw2_exec");
    cyc(1'b1, I_SW, 1'b0, idle_e(), "sw2_reset_mem");
    cyc(1'b0, I_SW, 1'b0, fetch_e(), "sw2_refetch");

    @(negedge clk);
    #1;
    done = 1'b1;
    if (exp_q.size() != 0 || checks < 12) begin
      errors++;
      $display("FAIL scoreboard: %0d vectors unchecked, %0d checks", exp_q.size(), checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multi-cycle RV32I control unit, and the driving end of the ALU interface.
- Decodes the instruction register and sequences the datapath through its states.
- Drives ALU_ctr and the operand selects; consumes the ALU's registered result flag `zero`.
- The ALU registers its result on posedge clk, so every ALU-dependent decision is taken one state after the operation is issued.

Parameters:
ILLEGAL_HALT, 1, 1: illegal opcode enters S_TRAP (sticky); 0: treated as NOP, returns to S_FETCH
ALU_CTR_W, 4, width of ALU_ctr

Ports:
clk  in  1  clock, all state changes on posedge
reset  in  1  synchronous, active-high
instr  in  32  instruction register contents
zero  in  1  ALU result == 0, valid one cycle after issue
ALU_ctr  out  4  ALU operation code
alu_a_sel  out  2  0=PC, 1=OLDPC, 2=RS1
alu_b_sel  out  2  0=RS2, 1=IMM, 2=CONST4
imm_type  out  3  0=I, 1=S, 2=B, 3=U, 4=J
pc_write  out  1  PC load enable
pc_src  out  2  0=ALU result, 1=TARGET reg, 2=ALU result with bit0 cleared
oldpc_write  out  1  OLDPC capture
ir_write  out  1  instruction register load
target_write  out  1  TARGET register captures ALU result
mem_addr_sel  out  1  0=PC, 1=ALU result
mem_write  out  1  store strobe
reg_write  out  1  register-file write enable
result_sel  out  2  0=ALU, 1=MEM, 2=PC, 3=IMM
illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Only the state register and the illegal flag are sequential. Outputs are a Moore decode of state, plus instr fields.
- Idle values: all enables 0, ALU_ctr=ADD, selects 0.
- Reset: while reset=1, outputs are forced to idle values. Next state is S_FETCH. illegal is cleared.
- Reset in any state aborts the instruction; no write enable is asserted in the reset cycle.
- ALU codes: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SLT=0111, SRA=1110, SLTU=1111.
- Funct decode (R/I-ALU):
  - 000: ADD, or SUB when R-type and funct7[5]=1 (I-type never SUB).
  - 001: SLL; 010: SLT; 011: SLTU; 100: XOR; 110: OR; 111: AND.
  - 101: SRL, or SRA when funct7[5]=1 (both R and I).
- Branch decode: BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
- S_FETCH: mem_addr_sel=0, ir_write=1, oldpc_write=1, ALU ADD PC+CONST4 -> S_DECODE.
- S_DECODE: pc_write=1, pc_src=0 (PC+4 now valid). Issue ALU ADD OLDPC+IMM with imm_type set per opcode (branch/JAL/AUIPC target) -> S_EXEC.
- S_EXEC, by opcode:
  - OP/OP-IMM: issue decoded op on RS1 with RS2/IMM -> S_ALU_WB.
  - LOAD/STORE: ADD RS1+IMM -> S_MEM.
  - BRANCH: target_write=1, issue compare op on RS1,RS2 -> S_BR_EVAL.
  - JAL: pc_write=1, pc_src=0 (target), reg_write=1, result_sel=2 -> S_FETCH.
  - JALR: ADD RS1+IMM -> S_JALR_WB.
  - LUI: reg_write=1, result_sel=3 -> S_FETCH.
  - AUIPC: reg_write=1, result_sel=0 -> S_FETCH.
  - Other opcode: illegal=1 and S_TRAP (ILLEGAL_HALT=1), else S_FETCH.
- S_ALU_WB: reg_write=1, result_sel=0 -> S_FETCH.
- S_MEM:
  - mem_addr_sel=1 throughout.
  - Store: mem_write=1 -> S_FETCH.
  - Load: -> S_LOAD_WB.
- S_LOAD_WB: reg_write=1, result_sel=1 -> S_FETCH.
- S_BR_EVAL: taken = BEQ: zero; BNE: !zero; BLT/BLTU: !zero; BGE/BGEU: zero. pc_write=taken, pc_src=1 -> S_FETCH.
- S_JALR_WB: pc_write=1, pc_src=2, reg_write=1, result_sel=2 -> S_FETCH.
- S_TRAP: all enables 0, stays until reset.
- CPI: ALU/load 4–5, store 4, branch 4, JAL/LUI/AUIPC 3, JALR 4.
- rd=x0 is not filtered; the register file ignores writes to x0.

Decomposition:
- Package alu_ctrl_pkg: ALU operation codes, opcode constants, state enumeration, select encodings for alu_a_sel, alu_b_sel, pc_src, result_sel and imm_type.
- Sub-module alu_op_dec (combinational): opcode, funct3, funct7[5] -> ALU_ctr.
- The FSM is instantiated once and holds all sequencing.

Test Plan:
- reset=1 for 2 cycles, then release -> first cycle: ir_write=1, oldpc_write=1, ALU_ctr=0000, alu_a_sel=0, alu_b_sel=2.
- instr=0x40208033 (sub x0,x1,x2) -> S_EXEC: ALU_ctr=0001, alu_b_sel=0; next cycle reg_write=1, result_sel=0; 4 cycles total.
- instr=0x4020D093 (srai x1,x1,2) -> S_EXEC: ALU_ctr=1110, alu_b_sel=1, imm_type=0.
- BEQ with zero=1 in S_BR_EVAL -> pc_write=1, pc_src=1. Repeat with zero=0 -> pc_write=0. BLTU shows ALU_ctr=1111 in S_EXEC.
- sw then lw -> sw: mem_write=1, mem_addr_sel=1 in S_MEM only. lw: S_LOAD_WB with result_sel=1.
- instr=0x00000000 -> illegal=1, outputs idle, held for 10 cycles; assert reset mid-S_MEM of a store -> mem_write=0 in the reset cycle, then S_FETCH.
